y86_execute_stage: RTL and testbench
====================================

Name: y86_execute_stage

Overview:
- Y86-64 pipeline execute stage. It drives the 64-bit ALU's operand and op inputs, and consumes the ALU's out/CC[2:0] result.
- Holds the architectural condition-code register and evaluates jXX/cmovXX conditions from it.
- Registers the E->M pipeline register under stall/bubble control from the pipeline hazard unit.
- Sits between the decode-stage register (E_*) and the memory stage (M_*).

Parameters:
- W, 64, datapath width.
- CC_RESET, 3'b100, condition-code reset value {ZF,SF,OF}.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- E_stat  input  3  status of the instruction in E (SAOK=1, SHLT=2, SADR=3, SINS=4).
- E_icode  input  4  instruction code in E.
- E_ifun  input  4  function code in E.
- E_valA, E_valB, E_valC  input  W  decode-stage operands / constant.
- E_dstE, E_dstM  input  4  destination register IDs (RNONE=4'hF).
- m_stat, W_stat  input  3  status in memory stage / writeback stage, used for CC suppression.
- alu_out  input  W  ALU result.
- alu_cc  input  3  ALU flags {ZF,SF,OF}.
- M_stall, M_bubble  input  1  M-register control.
- alu_inp1, alu_inp2  output  W  ALU operands; ALU computes inp1 op inp2.
- alu_op  output  2  00 add, 01 sub, 10 and, 11 xor.
- cc_q  output  3  CC register {ZF,SF,OF}.
- e_cnd  output  1  condition result for the instruction in E.
- e_dstE  output  4  effective dstE; forwarding source.
- e_valE  output  W  = alu_out; forwarding source.
- M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  output  3/4/1/W/W/4/4  M register.

Behaviour:
- Reset (async, immediate on rst_n low):
  - cc_q=CC_RESET.
  - M register = bubble values: stat=SAOK, icode=INOP(4'h1), cnd=0, valE=0, valA=0, dstE=dstM=RNONE.
- ALU operand and op selection (combinational):
  - alu_inp1 = E_valB for OPq(6), rmmovq(4), mrmovq(5), call(8), ret(9), pushq(A), popq(B); =0 for rrmovq/cmov(2) and irmovq(3); =0 otherwise.
  - alu_inp2 = E_valA for 2 and 6; E_valC for 3, 4, 5; -8 for 8 and A; +8 for 9 and B; 0 otherwise.
  - alu_op = E_ifun[1:0] when E_icode==6, else 2'b00.
  - Result: subq gives valB-valA; push/call give rsp-8.
- OPq with ifun>3: alu_op uses ifun[1:0]; E_stat is expected to already be SINS. The block does not check this.
- set_cc = (E_icode==6) && m_stat==SAOK && W_stat==SAOK && E_stat==SAOK.
  - When set_cc is true, cc_q<=alu_cc on the edge. Otherwise cc_q holds.
  - M_stall/M_bubble do not affect CC.
- e_cnd (combinational from cc_q, i.e. CC committed at an earlier edge), with ZF=cc_q[2], SF=cc_q[1], OF=cc_q[0]:
  - ifun 0: 1
  - ifun 1 (le): (SF^OF)|ZF
  - ifun 2 (l): SF^OF
  - ifun 3 (e): ZF
  - ifun 4 (ne): ~ZF
  - ifun 5 (ge): ~(SF^OF)
  - ifun 6 (g): ~(SF^OF)&~ZF
  - ifun 7..F: 0
- e_dstE = RNONE when E_icode==2 && !e_cnd; else E_dstE.
- e_valE = alu_out.
- M register update, in priority order:
  - rst_n low: reset values.
  - M_bubble: load bubble values.
  - M_stall: hold all fields.
  - Otherwise load {E_stat, E_icode, e_cnd, alu_out, E_valA, e_dstE, E_dstM}.
- M_bubble and M_stall asserted together is illegal. The bench asserts it never happens; RTL resolves it as bubble.
- Latency: the ALU path is combinational; M_* reflects E inputs 1 cycle later.
- A CC update and a condition evaluation in the same cycle: e_cnd uses the pre-edge cc_q. Bypassing is not allowed.

Decomposition:
- Package y86_pkg:
  - icode constants IHALT..IPOPQ
  - ifun constants (ALU ops, conditions)
  - stat codes SAOK/SHLT/SADR/SINS
  - RNONE
  - ALU op encodings
  - bubble-value constants
- One sub-module: y86_cond_eval. Purely combinational; inputs ifun and cc, output cnd. It is reused by fetch-side branch logic.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> cc_q=3'b100 and M_icode=4'h1, M_dstE=M_dstM=4'hF immediately, no clock needed.
- subq: E_icode=6, E_ifun=1, valA=22, valB=53, m/W_stat=1 -> alu_op=01, alu_inp1=53, alu_inp2=22. With modelled alu_out=31, alu_cc=000: after edge cc_q=000, M_valE=31.
- CC suppression: same OPq with m_stat=3 (SADR) and alu_cc=100 -> cc_q unchanged at 000; M register still loads.
- cmov: preload cc_q=010 (SF=1), E_icode=2, E_dstE=3.
  - ifun 2 -> e_cnd=1, M_dstE=3.
  - ifun 5 -> e_cnd=0, e_dstE=4'hF, M_dstE=4'hF.
- jXX with overflow: cc_q=001.
  - ifun 2 (l) -> 1; ifun 5 (ge) -> 0; ifun 6 (g) -> 0; ifun 3 (e) -> 0; ifun 9 -> 0.
  - cc_q=100: ifun 1 (le) -> 1.
- Stall/bubble: load M with pushq (alu_inp2=-8, valB=0x100 -> M_valE=0xF8).
  - Hold M_stall 3 cycles while E changes -> M unchanged.
  - Then M_bubble 1 cycle -> M_icode=1, M_stat=1, M_valE=0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 pipeline blocks. It holds the instruction
// and function codes, the status codes, the register-ID sentinel, the ALU op
// encodings, and the field values a bubble loads into a pipeline register.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Function codes: ALU operations (used with IOPQ)
    localparam logic [3:0] FADDQ = 4'h0;
    localparam logic [3:0] FSUBQ = 4'h1;
    localparam logic [3:0] FANDQ = 4'h2;
    localparam logic [3:0] FXORQ = 4'h3;

    // Function codes: conditions (used with IJXX / IRRMOVQ)
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // "No register" destination ID
    localparam logic [3:0] RNONE = 4'hF;

    // ALU op encodings driven onto alu_op
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    // Field values of a bubble (an inserted nop)
    localparam logic [2:0] BUBBLE_STAT  = SAOK;
    localparam logic [3:0] BUBBLE_ICODE = INOP;
    localparam logic       BUBBLE_CND   = 1'b0;
    localparam logic [3:0] BUBBLE_DST   = RNONE;

endpackage

// File: rtl/y86_cond_eval.sv
// Y86-64 condition evaluator. It is purely combinational and is shared by the
// execute stage and the fetch-side branch logic.
//   ifun : condition function code (0 = always, 1..6 = le/l/e/ne/ge/g)
//   cc   : condition codes {ZF,SF,OF}
//   cnd  : 1 when the condition holds; codes 7..F always give 0
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    output logic       cnd
);

    logic w_zf;
    logic w_sf;
    logic w_of;
    logic w_lt;

    assign w_zf = cc[2];
    assign w_sf = cc[1];
    assign w_of = cc[0];
    // Signed less-than after a compare: the sign is wrong exactly when it overflowed.
    assign w_lt = w_sf ^ w_of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = w_lt | w_zf;
            C_L:     cnd = w_lt;
            C_E:     cnd = w_zf;
            C_NE:    cnd = ~w_zf;
            C_GE:    cnd = ~w_lt;
            C_G:     cnd = ~w_lt & ~w_zf;
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage. It selects the ALU operands and op from the E register
// and holds the condition-code register. It evaluates the jXX/cmovXX condition
// and registers the E->M pipeline register.
//   clk, rst_n                 : clock; asynchronous active-low reset
//   E_*                        : decode-stage register outputs (instruction in E)
//   m_stat, W_stat             : later-stage status; an exception there blocks CC writes
//   alu_out, alu_cc            : result and flags returned by the external ALU
//   M_stall, M_bubble          : M-register control from the hazard unit
//   alu_inp1, alu_inp2, alu_op : ALU request (inp1 op inp2)
//   cc_q                       : condition-code register {ZF,SF,OF}
//   e_cnd, e_dstE, e_valE      : condition result and forwarding sources
//   M_*                        : E->M pipeline register
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int         W        = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [W-1:0] E_valC,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [2:0]   m_stat,
    input  logic [2:0]   W_stat,
    input  logic [W-1:0] alu_out,
    input  logic [2:0]   alu_cc,
    input  logic         M_stall,
    input  logic         M_bubble,
    output logic [W-1:0] alu_inp1,
    output logic [W-1:0] alu_inp2,
    output logic [1:0]   alu_op,
    output logic [2:0]   cc_q,
    output logic         e_cnd,
    output logic [3:0]   e_dstE,
    output logic [W-1:0] e_valE,
    output logic [2:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    // Stack-pointer adjustment constants at datapath width
    localparam logic [W-1:0] W_PLUS8  = W'(8);
    localparam logic [W-1:0] W_MINUS8 = ~W'(7);

    logic [2:0]   r_cc;
    logic         w_cnd;
    logic         w_set_cc;
    logic [3:0]   w_dste;

    logic [2:0]   r_m_stat;
    logic [3:0]   r_m_icode;
    logic         r_m_cnd;
    logic [W-1:0] r_m_vale;
    logic [W-1:0] r_m_vala;
    logic [3:0]   r_m_dste;
    logic [3:0]   r_m_dstm;

    // ALU operand / op selection
    always_comb begin
        alu_inp1 = '0;
        alu_inp2 = '0;
        alu_op   = ALU_ADD;

        case (E_icode)
            IOPQ, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_inp1 = E_valB;
            default:                                            alu_inp1 = '0;
        endcase

        case (E_icode)
            IRRMOVQ, IOPQ:             alu_inp2 = E_valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_inp2 = E_valC;
            ICALL, IPUSHQ:             alu_inp2 = W_MINUS8;
            IRET, IPOPQ:               alu_inp2 = W_PLUS8;
            default:                   alu_inp2 = '0;
        endcase

        // An OPq with an undefined ifun still drives ifun[1:0]. Decode has
        // already marked it SINS, and that also blocks the CC write below.
        if (E_icode == IOPQ) begin
            alu_op = E_ifun[1:0];
        end
    end

    // The condition is evaluated from the committed CC only. A flag update
    // that this same cycle produces is not bypassed.
    y86_cond_eval u_cond_eval (
        .ifun (E_ifun),
        .cc   (r_cc),
        .cnd  (w_cnd)
    );

    assign w_set_cc = (E_icode == IOPQ) && (E_stat == SAOK) &&
                      (m_stat == SAOK) && (W_stat == SAOK);

    // A cmov whose condition fails writes no register.
    assign w_dste = ((E_icode == IRRMOVQ) && !w_cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= CC_RESET;
        end else if (w_set_cc) begin
            r_cc <= alu_cc;
        end
    end

    // E->M register. Bubble wins over stall if both are asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_stat  <= BUBBLE_STAT;
            r_m_icode <= BUBBLE_ICODE;
            r_m_cnd   <= BUBBLE_CND;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= BUBBLE_DST;
            r_m_dstm  <= BUBBLE_DST;
        end else if (M_bubble) begin
            r_m_stat  <= BUBBLE_STAT;
            r_m_icode <= BUBBLE_ICODE;
            r_m_cnd   <= BUBBLE_CND;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= BUBBLE_DST;
            r_m_dstm  <= BUBBLE_DST;
        end else if (!M_stall) begin
            r_m_stat  <= E_stat;
            r_m_icode <= E_icode;
            r_m_cnd   <= w_cnd;
            r_m_vale  <= alu_out;
            r_m_vala  <= E_valA;
            r_m_dste  <= w_dste;
            r_m_dstm  <= E_dstM;
        end
    end

    assign cc_q    = r_cc;
    assign e_cnd   = w_cnd;
    assign e_dstE  = w_dste;
    assign e_valE  = alu_out;

    assign M_stat  = r_m_stat;
    assign M_icode = r_m_icode;
    assign M_cnd   = r_m_cnd;
    assign M_valE  = r_m_vale;
    assign M_valA  = r_m_vala;
    assign M_dstE  = r_m_dste;
    assign M_dstM  = r_m_dstm;

endmodule

// File: tb/tb_y86_execute_stage.sv
module tb_y86_execute_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  E_stat = 3'd1;
    logic [3:0]  E_icode = 4'h1;
    logic [3:0]  E_ifun = 4'h0;
    logic [63:0] E_valA = '0;
    logic [63:0] E_valB = '0;
    logic [63:0] E_valC = '0;
    logic [3:0]  E_dstE = 4'hF;
    logic [3:0]  E_dstM = 4'hF;
    logic [2:0]  m_stat = 3'd1;
    logic [2:0]  W_stat = 3'd1;
    logic [63:0] alu_out = '0;
    logic [2:0]  alu_cc = '0;
    logic        M_stall = 1'b0;
    logic        M_bubble = 1'b0;

    logic [63:0] alu_inp1, alu_inp2, e_valE, M_valE, M_valA;
    logic [1:0]  alu_op;
    logic [2:0]  cc_q, M_stat;
    logic        e_cnd, M_cnd;
    logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;

    int n_checks = 0;
    int n_errors = 0;

    y86_execute_stage #(.W(64), .CC_RESET(3'b100)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .alu_out(alu_out), .alu_cc(alu_cc),
        .M_stall(M_stall), .M_bubble(M_bubble),
        .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_op(alu_op),
        .cc_q(cc_q), .e_cnd(e_cnd), .e_dstE(e_dstE), .e_valE(e_valE),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [63:0] mdl_inp1(input logic [3:0] icode, input logic [63:0] valB);
        if (icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) return valB;
        return 64'd0;
    endfunction

    function automatic logic [63:0] mdl_inp2(input logic [3:0] icode,
                                             input logic [63:0] valA, input logic [63:0] valC);
        if (icode == 4'h2 || icode == 4'h6) return valA;
        if (icode inside {4'h3, 4'h4, 4'h5}) return valC;
        if (icode == 4'h8 || icode == 4'hA) return 64'd0 - 64'd8;
        if (icode == 4'h9 || icode == 4'hB) return 64'd8;
        return 64'd0;
    endfunction

    function automatic logic mdl_cond(input logic [3:0] ifun, input logic [2:0] cc);
        bit zf, lt;
        zf = cc[2];
        lt = (cc[1] != cc[0]);
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return lt || zf;
            4'd2: return lt;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !lt;
            4'd6: return !lt && !zf;
            default: return 1'b0;
        endcase
    endfunction

    logic [2:0]  md_cc;
    logic [2:0]  md_stat;
    logic [3:0]  md_icode, md_dstE, md_dstM;
    logic        md_cnd;
    logic [63:0] md_valE, md_valA;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cc <= 3'b100;
            md_stat <= 3'd1; md_icode <= 4'h1; md_cnd <= 1'b0;
            md_valE <= '0; md_valA <= '0; md_dstE <= 4'hF; md_dstM <= 4'hF;
        end else begin
            if (E_icode == 4'h6 && E_stat == 3'd1 && m_stat == 3'd1 && W_stat == 3'd1)
                md_cc <= alu_cc;
            if (M_bubble) begin
                md_stat <= 3'd1; md_icode <= 4'h1; md_cnd <= 1'b0;
                md_valE <= '0; md_valA <= '0; md_dstE <= 4'hF; md_dstM <= 4'hF;
            end else if (!M_stall) begin
                md_stat  <= E_stat;
                md_icode <= E_icode;
                md_cnd   <= mdl_cond(E_ifun, md_cc);
                md_valE  <= alu_out;
                md_valA  <= E_valA;
                md_dstE  <= (E_icode == 4'h2 && !mdl_cond(E_ifun, md_cc)) ? 4'hF : E_dstE;
                md_dstM  <= E_dstM;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic c;
        c = mdl_cond(E_ifun, md_cc);
        chk("stall_bubble_excl", 64'(M_stall && M_bubble), 64'd0);
        chk("alu_inp1", alu_inp1, mdl_inp1(E_icode, E_valB));
        chk("alu_inp2", alu_inp2, mdl_inp2(E_icode, E_valA, E_valC));
        chk("alu_op", 64'(alu_op), (E_icode == 4'h6) ? 64'(E_ifun[1:0]) : 64'd0);
        chk("cc_q", 64'(cc_q), 64'(md_cc));
        chk("e_cnd", 64'(e_cnd), 64'(c));
        chk("e_dstE", 64'(e_dstE), (E_icode == 4'h2 && !c) ? 64'hF : 64'(E_dstE));
        chk("e_valE", e_valE, alu_out);
        chk("M_stat", 64'(M_stat), 64'(md_stat));
        chk("M_icode", 64'(M_icode), 64'(md_icode));
        chk("M_cnd", 64'(M_cnd), 64'(md_cnd));
        chk("M_valE", M_valE, md_valE);
        chk("M_valA", M_valA, md_valA);
        chk("M_dstE", 64'(M_dstE), 64'(md_dstE));
        chk("M_dstM", 64'(M_dstM), 64'(md_dstM));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [2:0] es, input logic [2:0] ms, input logic [2:0] ws,
                         input logic [63:0] aout, input logic [2:0] acc,
                         input logic stall, input logic bubble);
        E_icode = icode; E_ifun = ifun; E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = dm; E_stat = es; m_stat = ms; W_stat = ws;
        alu_out = aout; alu_cc = acc; M_stall = stall; M_bubble = bubble;
        $display("drive icode=%h ifun=%h valA=%h valB=%h aout=%h acc=%b stall=%b bubble=%b",
                 icode, ifun, va, vb, aout, acc, stall, bubble);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_cc(input logic [2:0] flags);
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1, 64'd3, flags, 1'b0, 1'b0);
        tick();
        chk("preload_cc", 64'(cc_q), 64'(flags));
    endtask

    logic [3:0] jx_ifun [5] = '{4'h2, 4'h5, 4'h6, 4'h3, 4'h9};
    logic       jx_exp  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_cc", 64'(cc_q), 64'h4);
        chk("rst_M_icode", 64'(M_icode), 64'h1);
        chk("rst_M_dstE", 64'(M_dstE), 64'hF);
        chk("rst_M_dstM", 64'(M_dstM), 64'hF);

        // subq: 53 - 22
        drive(4'h6, 4'h1, 64'd22, 64'd53, 64'd0, 4'h2, 4'hF, 3'd1, 3'd1, 3'd1, 64'd31, 3'b000, 1'b0, 1'b0);
        #1;
        chk("subq_op", 64'(alu_op), 64'h1);
        chk("subq_inp1", alu_inp1, 64'd53);
        chk("subq_inp2", alu_inp2, 64'd22);
        tick();
        chk("subq_cc", 64'(cc_q), 64'h0);
        chk("subq_M_valE", M_valE, 64'd31);

        // CC suppression: m_stat=SADR
        drive(4'h6, 4'h1, 64'd22, 64'd53, 64'd0, 4'h2, 4'hF, 3'd1, 3'd3, 3'd1, 64'd7, 3'b100, 1'b0, 1'b0);
        tick();
        chk("supp_cc", 64'(cc_q), 64'h0);
        chk("supp_M_valE", M_valE, 64'd7);

        // mid-cycle async reset
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cc", 64'(cc_q), 64'h4);
        chk("arst_M_icode", 64'(M_icode), 64'h1);
        chk("arst_M_dstE", 64'(M_dstE), 64'hF);
        chk("arst_M_dstM", 64'(M_dstM), 64'hF);
        chk("arst_M_valE", M_valE, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // cmov with SF=1
        preload_cc(3'b010);
        drive(4'h2, 4'h2, 64'd9, 64'd0, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 3'd1, 64'd9, 3'b000, 1'b0, 1'b0);
        #1;
        chk("cmovl_cnd", 64'(e_cnd), 64'd1);
        tick();
        chk("cmovl_M_dstE", 64'(M_dstE), 64'h3);
        drive(4'h2, 4'h5, 64'd9, 64'd0, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 3'd1, 64'd9, 3'b000, 1'b0, 1'b0);
        #1;
        chk("cmovge_cnd", 64'(e_cnd), 64'd0);
        chk("cmovge_e_dstE", 64'(e_dstE), 64'hF);
        tick();
        chk("cmovge_M_dstE", 64'(M_dstE), 64'hF);

        // jXX with OF=1
        preload_cc(3'b001);
        for (int i = 0; i < 5; i++) begin
            drive(4'h7, jx_ifun[i], 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 3'd1, 3'd1, 3'd1, 64'd0, 3'b000, 1'b0, 1'b0);
            #1;
            chk($sformatf("jxx_of_ifun%0h", jx_ifun[i]), 64'(e_cnd), 64'(jx_exp[i]));
            tick();
        end
        preload_cc(3'b100);
        drive(4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF, 4'hF, 3'd1, 3'd1, 3'd1, 64'd0, 3'b000, 1'b0, 1'b0);
        #1;
        chk("jle_zf", 64'(e_cnd), 64'd1);
        tick();

        // same-cycle CC write and condition: old ZF=1 is used
        drive(4'h6, 4'h3, 64'd5, 64'd6, 64'd0, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1, 64'd3, 3'b000, 1'b0, 1'b0);
        #1;
        chk("nobypass_cnd", 64'(e_cnd), 64'd1);
        tick();
        chk("nobypass_cc", 64'(cc_q), 64'h0);
        chk("nobypass_M_cnd", 64'(M_cnd), 64'd1);

        // pushq then stall then bubble
        drive(4'hA, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4, 4'hF, 3'd1, 3'd1, 3'd1, 64'hF8, 3'b000, 1'b0, 1'b0);
        #1;
        chk("push_inp2", alu_inp2, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("push_inp1", alu_inp1, 64'h100);
        tick();
        chk("push_M_valE", M_valE, 64'hF8);
        for (int i = 0; i < 3; i++) begin
            drive(4'h6, 4'h0, 64'(i), 64'(i + 10), 64'd0, 4'h2, 4'h5, 3'd1, 3'd1, 3'd1,
                  64'(100 + i), 3'(i), 1'b1, 1'b0);
            tick();
            chk("stall_M_valE", M_valE, 64'hF8);
            chk("stall_M_icode", 64'(M_icode), 64'hA);
        end
        drive(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h2, 4'h5, 3'd1, 3'd1, 3'd1, 64'd77, 3'b000, 1'b0, 1'b1);
        tick();
        chk("bubble_M_icode", 64'(M_icode), 64'h1);
        chk("bubble_M_stat", 64'(M_stat), 64'h1);
        chk("bubble_M_valE", M_valE, 64'd0);
        chk("bubble_M_dstE", 64'(M_dstE), 64'hF);

        drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1, 3'd1, 64'd0, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
